// File: rtl/pattest_output_tern_if.sv
// Video output bundle from the raster timing/pattern generator to the display encoder.
interface pattest_output_tern_if;
  logic        test_vsync_out;
  logic        test_hsync_out;
  logic        test_de_out;
  logic [23:0] test_rgb_out;

  modport master (output test_vsync_out, test_hsync_out, test_de_out, test_rgb_out);
  modport slave  (input  test_vsync_out, test_hsync_out, test_de_out, test_rgb_out);
endinterface

// File: rtl/pattest_output_tern.sv
// Raster timing and 8-bar colour test pattern generator (640x480@60 by default).
// Free-running H/V counters; every output is decoded from the counters and registered.
module pattest_output_tern #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                  test_clk_in,
  input  logic                  test_rst_in,
  pattest_output_tern_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);

  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic [2:0]  bar;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end

    // vsync decodes only vcnt, so it changes on whole-line boundaries at hcnt=0
    de_d    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hsync_d = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;

    bar   = 3'(hcnt_q / BAR_W);
    rgb_d = '0;
    if (de_d) begin
      case (bar)
        3'd0:    rgb_d = 24'hFFFFFF;
        3'd1:    rgb_d = 24'hFFFF00;
        3'd2:    rgb_d = 24'h00FFFF;
        3'd3:    rgb_d = 24'h00FF00;
        3'd4:    rgb_d = 24'hFF00FF;
        3'd5:    rgb_d = 24'hFF0000;
        3'd6:    rgb_d = 24'h0000FF;
        default: rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge test_clk_in or negedge test_rst_in) begin
    if (!test_rst_in) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vid.test_vsync_out = vsync_q;
  assign vid.test_hsync_out = hsync_q;
  assign vid.test_de_out    = de_q;
  assign vid.test_rgb_out   = rgb_q;

endmodule

// File: tb/tb_pattest_output_tern.sv
// Bench for the raster generator: a full-size instance for line timing and a short-frame
// instance for vertical timing, both checked every cycle against a position-based model.
module tb_pattest_output_tern;

  logic clk;
  logic rst_n;

  pattest_output_tern_if vid_a ();
  pattest_output_tern_if vid_b ();

  pattest_output_tern u_a (
    .test_clk_in (clk),
    .test_rst_in (rst_n),
    .vid         (vid_a)
  );

  // Short frame: 6 active lines, sync on lines 8..9, 13 lines total (10400 clocks)
  pattest_output_tern #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_b (
    .test_clk_in (clk),
    .test_rst_in (rst_n),
    .vid         (vid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 50) $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Expected {vsync, hsync, de, rgb} after n rising edges since reset release.
  function automatic logic [26:0] ref_out(int n, int vact, int vs_beg, int vs_end, int vtot);
    int p, h, v;
    logic de, hs, vs;
    logic [23:0] rgb;
    if (n == 0) return {1'b1, 1'b1, 1'b0, 24'h0};
    p   = (n - 1) % (800 * vtot);
    h   = p % 800;
    v   = p / 800;
    de  = (h < 640) && (v < vact);
    hs  = !((h >= 656) && (h < 752));
    vs  = !((v >= vs_beg) && (v < vs_end));
    rgb = de ? bars[h / 80] : 24'h0;
    return {vs, hs, de, rgb};
  endfunction

  int n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  logic mon_en;
  logic prev_hs, prev_de, prev_vs;
  int   hs_fall, vs_fall, vs_cnt;
  logic de_fell;

  always @(negedge clk) begin
    logic [26:0] ea, eb;
    ea = ref_out(n, 480, 490, 492, 525);
    eb = ref_out(n, 6, 8, 10, 13);
    chk("a_vsync", vid_a.test_vsync_out, ea[26]);
    chk("a_hsync", vid_a.test_hsync_out, ea[25]);
    chk("a_de",    vid_a.test_de_out,    ea[24]);
    chk("a_rgb",   vid_a.test_rgb_out,   ea[23:0]);
    chk("b_vsync", vid_b.test_vsync_out, eb[26]);
    chk("b_hsync", vid_b.test_hsync_out, eb[25]);
    chk("b_de",    vid_b.test_de_out,    eb[24]);
    chk("b_rgb",   vid_b.test_rgb_out,   eb[23:0]);

    if (!mon_en) begin
      hs_fall = -1;
      vs_fall = -1;
      vs_cnt  = 0;
      de_fell = 1'b0;
    end else begin
      if (prev_de && !vid_a.test_de_out && !de_fell) begin
        chk("de_first_fall", n, 641);
        de_fell = 1'b1;
      end
      if (prev_hs && !vid_a.test_hsync_out) begin
        if (hs_fall >= 0) chk("hs_period", n - hs_fall, 800);
        else              chk("hs_first", n, 657);
        hs_fall = n;
      end
      if (!prev_hs && vid_a.test_hsync_out && hs_fall >= 0) chk("hs_width", n - hs_fall, 96);
      if (prev_vs && !vid_b.test_vsync_out) begin
        if (vs_fall >= 0) chk("vs_period", n - vs_fall, 10400);
        else              chk("vs_first", n, 6401);
        vs_fall = n;
        vs_cnt++;
      end
      if (!prev_vs && vid_b.test_vsync_out && vs_fall >= 0) chk("vs_width", n - vs_fall, 1600);
    end
    prev_hs = vid_a.test_hsync_out;
    prev_de = vid_a.test_de_out;
    prev_vs = vid_b.test_vsync_out;
  end

  initial begin
    int len;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    repeat (510) @(posedge clk);
    #2 rst_n = 1'b1;

    // Random mid-line resets while de is high; outputs must clear before any clock edge.
    for (int r = 0; r < 3; r++) begin
      len = 800 * $urandom_range(1, 2) + $urandom_range(100, 600);
      repeat (len) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_a_de",  vid_a.test_de_out,    1'b0);
      chk("async_a_rgb", vid_a.test_rgb_out,   24'h0);
      chk("async_a_hs",  vid_a.test_hsync_out, 1'b1);
      chk("async_b_de",  vid_b.test_de_out,    1'b0);
      chk("async_b_vs",  vid_b.test_vsync_out, 1'b1);
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #2 rst_n = 1'b1;
    end

    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat ($urandom_range(2, 10)) @(posedge clk);
    #2 begin
      rst_n  = 1'b1;
      mon_en = 1'b1;
    end
    repeat (49000) @(posedge clk);
    #2 chk("vs_count", vs_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
